// File: rtl/current_pu_multi_channel_pkg.sv
// Shared constants for the multi-channel current per-unit stage:
// FSM encodings, the per-unit scale constant and the divisor shift amounts.
package current_pu_multi_channel_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Imax*160 is built as (Imax<<7)+(Imax<<5)
  localparam int DIV_SHIFT_A = 7;
  localparam int DIV_SHIFT_B = 5;

  // K = (2^(W-1)-1)*10, the numerator scale applied to |x|
  function automatic int current_pu_k(input int w);
    return ((1 << (w - 1)) - 1) * 10;
  endfunction

endpackage

// File: rtl/current_pu_seq_divider.sv
// Sequential restoring divider for the per-unit stage: NUM = |x|*K over D = Imax*160,
// one quotient bit per cycle MSB-first, with a saturation pre-check at start.
module current_pu_seq_divider
  import current_pu_multi_channel_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] mag_in,
  input  logic [DATA_WIDTH-1:0] imax_in,
  output logic                  last_out,
  output logic [DATA_WIDTH-1:0] quot_out,
  output logic                  sat_out
);

  localparam int W     = DATA_WIDTH;
  localparam int NUM_W = 2 * W + 3;
  localparam int D_W   = W + 8;
  localparam int R_W   = 2 * W + 8;
  localparam int CNT_W = $clog2(W);
  localparam logic [W+2:0] K = (W + 3)'(current_pu_k(W));

  function automatic logic [NUM_W-1:0] mul_k(input logic [W-1:0] m);
    logic [NUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < W + 3; i++) begin
      if (K[i]) acc = acc + ({{(W + 3){1'b0}}, m} << i);
    end
    return acc;
  endfunction

  logic [NUM_W-1:0] num_c;
  logic [D_W-1:0]   imax_ext;
  logic [D_W-1:0]   den_c;
  logic             sat_c;

  logic [R_W-1:0]   rem_q;
  logic [R_W-1:0]   dsh_q;
  logic [W-1:0]     quot_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             sat_q;

  always_comb begin
    num_c    = mul_k(mag_in);
    imax_ext = {8'd0, imax_in};
    den_c    = (imax_ext << DIV_SHIFT_A) + (imax_ext << DIV_SHIFT_B);
    // quotient must fit in W bits, otherwise the result is forced to full scale
    sat_c    = (den_c == '0) || ({5'd0, num_c} >= {den_c, {W{1'b0}}});
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      sat_q  <= 1'b0;
    end else if (start) begin
      rem_q  <= {5'd0, num_c};
      dsh_q  <= {1'b0, den_c, {(W - 1){1'b0}}};
      quot_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b1;
      sat_q  <= sat_c;
    end else if (run_q) begin
      if (rem_q >= dsh_q) begin
        rem_q  <= rem_q - dsh_q;
        quot_q <= {quot_q[W-2:0], 1'b1};
      end else begin
        quot_q <= {quot_q[W-2:0], 1'b0};
      end
      dsh_q <= dsh_q >> 1;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(W - 1)) run_q <= 1'b0;
    end
  end

  assign last_out = run_q && (cnt_q == CNT_W'(W - 1));
  assign quot_out = quot_q;
  assign sat_out  = sat_q;

endmodule

// File: rtl/current_pu_multi_channel.sv
// N-channel phase-current per-unit converter sharing one sequential divider under
// a round-robin arbiter. Optional overrun counters: define CURRENT_PU_OVERRUN_EN.
module current_pu_multi_channel
  import current_pu_multi_channel_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CH_NUM     = 3
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic [CH_NUM-1:0]            current_valid_in,
  input  logic [CH_NUM*DATA_WIDTH-1:0] current_value_in,
  input  logic [DATA_WIDTH-1:0]        pmsm_imax_in,
  output logic [CH_NUM*DATA_WIDTH-1:0] current_pu_out,
  output logic [CH_NUM-1:0]            current_done_out,
  output logic                         busy_out
`ifdef CURRENT_PU_OVERRUN_EN
  ,
  output logic [CH_NUM*8-1:0]          overrun_cnt_out,
  input  logic                         overrun_clr_in
`endif
);

  localparam int W     = DATA_WIDTH;
  localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W - 1){1'b1}}};

  function automatic logic signed [W-1:0] pu_result(input logic sat, input logic [W-1:0] quot,
                                                    input logic neg, input logic zero);
    logic [W-1:0] mag;
    mag = (sat || (quot > MAX_POS)) ? MAX_POS : quot;
    if (zero) return '0;
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  logic signed [W-1:0] hold_q [CH_NUM];
  logic signed [W-1:0] pu_q   [CH_NUM];
  logic [CH_NUM-1:0]   pend_q;
  logic [CH_NUM-1:0]   done_q;
  logic [PTR_W-1:0]    rr_ptr_q;
  logic [1:0]          state_q;
  logic [PTR_W-1:0]    ch_q;
  logic signed [W-1:0] sample_q;
  logic                sign_q;
  logic                zero_q;

  logic                grant_vld;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    scan_idx;
  logic                do_grant;
  logic [W-1:0]        mag_c;
  logic                div_last;
  logic [W-1:0]        div_quot;
  logic                div_sat;

  // scan downward so the final hit is the first pending channel at/after rr_ptr
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int off = CH_NUM - 1; off >= 0; off--) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + off) % CH_NUM);
      if (pend_q[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign do_grant = (state_q == ST_IDLE) && grant_vld;
  assign mag_c    = sample_q[W-1] ? $unsigned(-sample_q) : $unsigned(sample_q);

  // capture: a new pulse re-arms pend even on the channel being granted
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      for (int c = 0; c < CH_NUM; c++) hold_q[c] <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (do_grant && (grant_idx == PTR_W'(c))) pend_q[c] <= 1'b0;
        if (current_valid_in[c]) begin
          pend_q[c] <= 1'b1;
          hold_q[c] <= current_value_in[c*W +: W];
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      ch_q     <= '0;
      sample_q <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= '0;
      for (int c = 0; c < CH_NUM; c++) pu_q[c] <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            ch_q     <= grant_idx;
            sample_q <= hold_q[grant_idx];
            rr_ptr_q <= PTR_W'((int'(grant_idx) + 1) % CH_NUM);
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          sign_q  <= sample_q[W-1];
          zero_q  <= (sample_q == '0);
          state_q <= ST_DIV;
        end
        ST_DIV: begin
          if (div_last) state_q <= ST_DONE;
        end
        default: begin
          pu_q[ch_q]   <= pu_result(div_sat, div_quot, sign_q, zero_q);
          done_q[ch_q] <= 1'b1;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  current_pu_seq_divider #(.DATA_WIDTH(W)) u_div (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .start    (state_q == ST_LOAD),
    .mag_in   (mag_c),
    .imax_in  (pmsm_imax_in),
    .last_out (div_last),
    .quot_out (div_quot),
    .sat_out  (div_sat)
  );

  always_comb begin
    current_pu_out = '0;
    for (int c = 0; c < CH_NUM; c++) current_pu_out[c*W +: W] = pu_q[c];
  end

  assign current_done_out = done_q;
  // queued work keeps busy high across the one-cycle IDLE between conversions
  assign busy_out = (state_q != ST_IDLE) || (|pend_q);

`ifdef CURRENT_PU_OVERRUN_EN
  logic [7:0] ovr_q [CH_NUM];

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CH_NUM; c++) ovr_q[c] <= '0;
    end else if (overrun_clr_in) begin
      for (int c = 0; c < CH_NUM; c++) ovr_q[c] <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (current_valid_in[c] && pend_q[c] && (ovr_q[c] != 8'hFF)) ovr_q[c] <= ovr_q[c] + 8'd1;
      end
    end
  end

  always_comb begin
    overrun_cnt_out = '0;
    for (int c = 0; c < CH_NUM; c++) overrun_cnt_out[c*8 +: 8] = ovr_q[c];
  end
`endif

endmodule

// File: tb/tb_current_pu_multi_channel.sv
// Directed scoreboard bench for current_pu_multi_channel (W=16, N=3).
module tb_current_pu_multi_channel;

  localparam int W = 16;
  localparam int N = 3;

  typedef struct {
    int ch;
    int val;
    int cyc;
  } exp_t;

  logic             sys_clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     valid   = '0;
  logic [N*W-1:0]   value   = '0;
  logic [W-1:0]     imax    = '0;
  logic [N*W-1:0]   pu_out;
  logic [N-1:0]     done;
  logic             busy;
`ifdef CURRENT_PU_OVERRUN_EN
  logic [N*8-1:0]   ovr_cnt;
  logic             ovr_clr = 1'b0;
`endif

  current_pu_multi_channel #(.DATA_WIDTH(W), .CH_NUM(N)) dut (
    .sys_clk          (sys_clk),
    .reset_n          (reset_n),
    .current_valid_in (valid),
    .current_value_in (value),
    .pmsm_imax_in     (imax),
    .current_pu_out   (pu_out),
    .current_done_out (done),
    .busy_out         (busy)
`ifdef CURRENT_PU_OVERRUN_EN
    ,
    .overrun_cnt_out  (ovr_cnt),
    .overrun_clr_in   (ovr_clr)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int   cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  int   exp_pu[N];
  int   last_cap = 0;

  function automatic int model(input int x, input int im);
    longint m, num, d, q;
    if (x == 0) return 0;
    m   = (x < 0) ? -longint'(x) : longint'(x);
    num = m * 327670;
    d   = longint'(im) * 160;
    if (d == 0) q = 32767;
    else begin
      q = num / d;
      if (q > 32767) q = 32767;
    end
    return (x < 0) ? int'(-q) : int'(q);
  endfunction

  function automatic logic [N*W-1:0] pack_exp();
    logic [N*W-1:0] v;
    logic [W-1:0]   s;
    v = '0;
    for (int c = 0; c < N; c++) begin
      s = exp_pu[c][W-1:0];
      v[c*W +: W] = s;
    end
    return v;
  endfunction

  // scoreboard check on every done pulse
  exp_t             mon_e;
  logic signed [W-1:0] mon_got;
  always @(negedge sys_clk) begin
    if (reset_n) begin
      for (int c = 0; c < N; c++) begin
        if (done[c]) begin
          vectors++;
          assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL unexpected_done ch %0d got pulse expected none", c);
          end
          if (sb.size() != 0) begin
            mon_e   = sb.pop_front();
            mon_got = pu_out[c*W +: W];
            vectors++;
            assert (c === mon_e.ch) else begin
              miscompares++;
              $error("FAIL done_order got ch %0d expected ch %0d", c, mon_e.ch);
            end
            vectors++;
            assert (int'(mon_got) === mon_e.val) else begin
              miscompares++;
              $error("FAIL result ch %0d got %0d expected %0d", c, mon_got, mon_e.val);
            end
            vectors++;
            assert (cyc === mon_e.cyc) else begin
              miscompares++;
              $error("FAIL latency ch %0d got edge %0d expected edge %0d", c, cyc, mon_e.cyc);
            end
            exp_pu[mon_e.ch] = mon_e.val;
            vectors++;
            assert (pu_out === pack_exp()) else begin
              miscompares++;
              $error("FAIL hold_bus got %h expected %h", pu_out, pack_exp());
            end
          end
        end
      end
    end
  end

  task automatic send(input int ch, input int x, input int lat);
    logic [W-1:0] xs;
    exp_t e;
    xs = x[W-1:0];
    @(negedge sys_clk);
    value[ch*W +: W] = xs;
    valid[ch] = 1'b1;
    last_cap = cyc + 1;
    e.ch = ch; e.val = model(x, int'(imax)); e.cyc = last_cap + lat;
    sb.push_back(e);
    @(negedge sys_clk);
    valid = '0;
  endtask

  task automatic pulse(input int ch, input int x);
    logic [W-1:0] xs;
    xs = x[W-1:0];
    @(negedge sys_clk);
    value[ch*W +: W] = xs;
    valid[ch] = 1'b1;
    @(negedge sys_clk);
    valid = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    vectors++;
    assert (n < 300) else begin
      miscompares++;
      $error("FAIL drain_timeout got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    assert (pu_out === '0) else begin
      miscompares++;
      $error("FAIL %s_pu got %h expected 0", tag, pu_out);
    end
    vectors++;
    assert (done === '0) else begin
      miscompares++;
      $error("FAIL %s_done got %b expected 0", tag, done);
    end
    vectors++;
    assert (busy === 1'b0) else begin
      miscompares++;
      $error("FAIL %s_busy got %b expected 0", tag, busy);
    end
  endtask

  initial begin
    int busy_cnt;
    exp_t e;
    for (int c = 0; c < N; c++) exp_pu[c] = 0;
    imax = 16'd100;
    repeat (3) @(negedge sys_clk);
    check_zero("reset");
    reset_n = 1'b1;
    @(negedge sys_clk);
    check_zero("post_reset");

    send(0, 1000, 19);    wait_drain();
    send(0, -1000, 19);   wait_drain();
    send(1, 2000, 19);    wait_drain();
    send(1, -32768, 19);  wait_drain();
    imax = 16'd0;
    send(2, 5, 19);       wait_drain();
    send(2, -5, 19);      wait_drain();
    send(2, 0, 19);       wait_drain();

    // three channels at once, served in round-robin order
    imax = 16'd100;
    @(negedge sys_clk);
    for (int c = 0; c < N; c++) value[c*W +: W] = 16'd1000;
    valid = '1;
    last_cap = cyc + 1;
    for (int c = 0; c < N; c++) begin
      e.ch = c; e.val = model(1000, 100); e.cyc = last_cap + 19 * (c + 1);
      sb.push_back(e);
    end
    @(negedge sys_clk);
    valid = '0;
    busy_cnt = 0;
    repeat (80) begin
      if (busy) busy_cnt++;
      @(negedge sys_clk);
    end
    vectors++;
    assert (busy_cnt === 57) else begin
      miscompares++;
      $error("FAIL busy_span got %0d cycles expected 57", busy_cnt);
    end
    wait_drain();

`ifdef CURRENT_PU_OVERRUN_EN
    send(1, 1000, 19);
    repeat (2) @(negedge sys_clk);
    pulse(0, 1000);
    repeat (2) @(negedge sys_clk);
    pulse(0, 2000);
    e.ch = 0; e.val = model(2000, 100); e.cyc = last_cap + 38;
    sb.push_back(e);
    wait_drain();
    vectors++;
    assert (ovr_cnt === 24'h000001) else begin
      miscompares++;
      $error("FAIL overrun_cnt got %h expected 000001", ovr_cnt);
    end
    @(negedge sys_clk);
    ovr_clr = 1'b1;
    @(negedge sys_clk);
    ovr_clr = 1'b0;
    vectors++;
    assert (ovr_cnt === 24'h000000) else begin
      miscompares++;
      $error("FAIL overrun_clr got %h expected 000000", ovr_cnt);
    end
`endif

    // reset in the middle of a conversion discards it
    pulse(0, 1000);
    repeat (8) @(negedge sys_clk);
    #2 reset_n = 1'b0;
    #1 check_zero("mid_reset");
    for (int c = 0; c < N; c++) exp_pu[c] = 0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    reset_n = 1'b1;
    send(0, 1000, 19);
    wait_drain();

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL leftover got %0d entries expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
